// File: rtl/sd_arb_pkg.sv
// Shared definitions for the SD io arbiter: requester count, timeout default,
// FSM state encoding and the round-robin pick helper.
package sd_arb_pkg;

  // Number of requesters sharing the io controller.
  localparam int NREQ = 2;

  // Default ISSUE wait, in clk cycles, before an unacknowledged request is abandoned.
  localparam logic [23:0] TIMEOUT_DEFAULT = 24'd12_000_000;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  // Round-robin choice between two requesters: with both pending, the one
  // not served last wins; with one pending, that one wins.
  function automatic logic pick_grant(input logic [NREQ-1:0] pending,
                                      input logic            last_grant);
    logic winner;
    if (pending == 2'b11) begin
      winner = ~last_grant;
    end else begin
      winner = pending[1];
    end
    return winner;
  endfunction

endpackage

// File: rtl/sd_io_arbiter_sync_edge.sv
// Two-flop synchronizer for an asynchronous control line, followed by a
// third flop used only for edge detection. The rise/fall outputs are
// combinational one-cycle pulses; a consumer that registers them forwards
// the event exactly three clk edges after the asynchronous transition.
module sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  // sync_q[0..1] form the metastability chain, sync_q[2] holds the previous synchronized level.
  logic [2:0] sync_q;
  logic [2:0] sync_d;

  assign sync_d = {sync_q[1:0], async_i};

  // Shift the asynchronous input through the synchronizer chain.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rise_o =  sync_q[1] & ~sync_q[2];
  assign fall_o = ~sync_q[1] &  sync_q[2];

endmodule

// File: rtl/sd_io_arbiter.sv
// Two-requester arbiter in front of the SD card io controller. Grants one
// sector read/write at a time round-robin, drives the io request lines,
// routes byte strobes and write data for the granted requester, and
// abandons a request that is not acknowledged within TIMEOUT cycles.
module sd_io_arbiter
  import sd_arb_pkg::*;
#(
  parameter logic [23:0] TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NREQ-1:0] req_rd,
  input  logic [NREQ-1:0] req_wr,
  input  logic [31:0]     req_lba0,
  input  logic [31:0]     req_lba1,
  input  logic [7:0]      req_dout0,
  input  logic [7:0]      req_dout1,
  output logic [NREQ-1:0] req_din_strobe,
  output logic [NREQ-1:0] req_dout_strobe,
  output logic [NREQ-1:0] req_done,
  output logic [NREQ-1:0] req_err,
  output logic            io_rd,
  output logic            io_wr,
  output logic [31:0]     io_lba,
  input  logic            io_ack,
  input  logic            io_din_strobe,
  input  logic            io_dout_strobe,
  output logic [7:0]      io_dout
);

  // Synchronized edge events from the io controller.
  logic ack_rise;
  logic ack_fall;
  logic din_rise;
  logic din_fall;
  logic dout_rise;
  logic dout_fall;

  sync_edge u_sync_ack (
    .clk    (clk),
    .reset_n(reset_n),
    .async_i(io_ack),
    .rise_o (ack_rise),
    .fall_o (ack_fall)
  );

  sync_edge u_sync_din (
    .clk    (clk),
    .reset_n(reset_n),
    .async_i(io_din_strobe),
    .rise_o (din_rise),
    .fall_o (din_fall)
  );

  sync_edge u_sync_dout (
    .clk    (clk),
    .reset_n(reset_n),
    .async_i(io_dout_strobe),
    .rise_o (dout_rise),
    .fall_o (dout_fall)
  );

  // Only rising strobe edges advance a byte; the falling edges are not needed.
  logic unused_edges;
  assign unused_edges = din_fall ^ dout_fall;

  // FSM and transaction context.
  arb_state_e      state_q, state_d;
  logic            grant_q, grant_d;
  logic            last_q, last_d;
  logic [31:0]     lba_q, lba_d;
  logic [23:0]     cnt_q, cnt_d;
  logic            io_rd_q, io_rd_d;
  logic            io_wr_q, io_wr_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [NREQ-1:0] err_q, err_d;
  logic [NREQ-1:0] din_stb_q, din_stb_d;
  logic [NREQ-1:0] dout_stb_q, dout_stb_d;

  // Arbitration inputs, only acted on in IDLE.
  logic [NREQ-1:0] pending;
  logic            grant_pick;
  logic            timeout_hit;

  assign pending     = req_rd | req_wr;
  assign grant_pick  = pick_grant(pending, last_q);
  assign timeout_hit = (cnt_q == TIMEOUT - 24'd1);

  // Next-state and registered-output logic for the arbiter FSM.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    lba_d      = lba_q;
    cnt_d      = cnt_q;
    io_rd_d    = io_rd_q;
    io_wr_d    = io_wr_q;
    done_d     = '0;
    err_d      = '0;
    din_stb_d  = '0;
    dout_stb_d = '0;

    case (state_q)
      ST_IDLE: begin
        if (|pending) begin
          // Latch the whole request; a simultaneous read wins over a write.
          grant_d = grant_pick;
          lba_d   = grant_pick ? req_lba1 : req_lba0;
          io_rd_d = req_rd[grant_pick];
          io_wr_d = ~req_rd[grant_pick];
          cnt_d   = '0;
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (ack_rise) begin
          // An ack arriving on the expiry cycle still wins.
          io_rd_d = 1'b0;
          io_wr_d = 1'b0;
          state_d = ST_BUSY;
        end else if (timeout_hit) begin
          err_d[grant_q] = 1'b1;
          io_rd_d        = 1'b0;
          io_wr_d        = 1'b0;
          last_d         = grant_q;
          state_d        = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end

      ST_BUSY: begin
        din_stb_d[grant_q]  = din_rise;
        dout_stb_d[grant_q] = dout_rise;
        if (ack_fall) begin
          done_d[grant_q] = 1'b1;
          state_d         = ST_DONE;
        end
      end

      ST_DONE: begin
        last_d  = grant_q;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset leaves requester 0 first in line.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= 1'b0;
      last_q     <= 1'b1;
      lba_q      <= '0;
      cnt_q      <= '0;
      io_rd_q    <= 1'b0;
      io_wr_q    <= 1'b0;
      done_q     <= '0;
      err_q      <= '0;
      din_stb_q  <= '0;
      dout_stb_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      lba_q      <= lba_d;
      cnt_q      <= cnt_d;
      io_rd_q    <= io_rd_d;
      io_wr_q    <= io_wr_d;
      done_q     <= done_d;
      err_q      <= err_d;
      din_stb_q  <= din_stb_d;
      dout_stb_q <= dout_stb_d;
    end
  end

  assign io_rd           = io_rd_q;
  assign io_wr           = io_wr_q;
  assign io_lba          = lba_q;
  assign req_done        = done_q;
  assign req_err         = err_q;
  assign req_din_strobe  = din_stb_q;
  assign req_dout_strobe = dout_stb_q;

  // Write data follows the granted requester live while a transfer is in flight.
  assign io_dout = ((state_q == ST_ISSUE) || (state_q == ST_BUSY))
                 ? (grant_q ? req_dout1 : req_dout0)
                 : 8'hFF;

endmodule
